key_buffer: RTL and testbench



---
 rtl/key_buffer.sv | 129 ++++++++++++
 tb/tb_key_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_buffer.sv
// rtl/key_buffer.sv - bcrypt key store: byte-stream load, cyclic expansion to 72 bytes, 8-byte window reads.
// Optional NUL terminator appended on load when KEY_NUL_TERM_EN is defined.
module key_buffer (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_start,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  input  logic            byte_last,
  output logic            byte_ready,
  input  logic [6:0]      key_addr,
  output logic [7:0][7:0] key_data,
  output logic            key_ready,
  output logic [6:0]      key_len,
  output logic            truncated
);

  localparam int         MAX_KEY_BYTES = 72;
  localparam logic [6:0] KEY_MAX       = 7'd72;
  localparam logic [6:0] KEY_LAST      = 7'd71;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_READY} state_t;

  state_t     state_q;
  logic [7:0] buf_q [MAX_KEY_BYTES];
  logic [6:0] n_q;
  logic [6:0] key_len_q;
  logic [6:0] wr_q;
  logic [6:0] src_q;
  logic       truncated_q;
  logic       key_ready_q;
  logic       byte_ready_q;

  logic       accept;
  logic       store;
  logic [6:0] n_d;
  logic [6:0] len_d;
  logic       term_wr;
  logic [7:0] idx;

  always_comb begin
    accept = (state_q == S_LOAD) && byte_valid && !load_start;
    store  = accept && (n_q < KEY_MAX);
    n_d    = store ? n_q + 7'd1 : n_q;
`ifdef KEY_NUL_TERM_EN
    term_wr = accept && byte_last && (n_d < KEY_MAX);
    len_d   = term_wr ? n_d + 7'd1 : n_d;
`else
    term_wr = 1'b0;
    len_d   = n_d;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      key_len_q    <= '0;
      wr_q         <= '0;
      src_q        <= '0;
      truncated_q  <= 1'b0;
      key_ready_q  <= 1'b0;
      byte_ready_q <= 1'b0;
    end else if (load_start) begin
      state_q      <= S_LOAD;
      n_q          <= '0;
      key_len_q    <= '0;
      truncated_q  <= 1'b0;
      key_ready_q  <= 1'b0;
      byte_ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            n_q <= n_d;
            if (!store) truncated_q <= 1'b1;
            if (byte_last) begin
              key_len_q    <= len_d;
              wr_q         <= len_d;
              src_q        <= '0;
              byte_ready_q <= 1'b0;
              if (len_d < KEY_MAX) begin
                state_q <= S_EXPAND;
              end else begin
                state_q     <= S_READY;
                key_ready_q <= 1'b1;
              end
            end
          end
        end
        S_EXPAND: begin
          wr_q  <= wr_q + 7'd1;
          src_q <= src_q + 7'd1;
          if (wr_q == KEY_LAST) begin
            state_q     <= S_READY;
            key_ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // src trails wr by key_len, so every copied byte has already been written.
  always_ff @(posedge clk) begin
    if (store) buf_q[n_q] <= byte_data;
    if (term_wr) buf_q[n_d] <= 8'h00;
    if (state_q == S_EXPAND && !load_start)
      buf_q[wr_q] <= (key_len_q == 7'd0) ? 8'h00 : buf_q[src_q];
  end

  always_comb begin
    key_data = '0;
    idx      = '0;
    if (key_ready_q && key_addr < KEY_MAX) begin
      for (int i = 0; i < 8; i++) begin
        idx = {1'b0, key_addr} + 8'(i);
        if (idx >= 8'd72) idx = idx - 8'd72;
        key_data[i] = buf_q[idx[6:0]];
      end
    end
  end

  assign byte_ready = byte_ready_q;
  assign key_ready  = key_ready_q;
  assign key_len    = key_len_q;
  assign truncated  = truncated_q;

endmodule

// File: tb/tb_key_buffer.sv
// tb/tb_key_buffer.sv - scoreboard bench for key_buffer (follows KEY_NUL_TERM_EN like the RTL).
`timescale 1ns/1ps
module tb_key_buffer;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load_start = 1'b0;
  logic            byte_valid = 1'b0;
  logic [7:0]      byte_data = 8'h00;
  logic            byte_last = 1'b0;
  logic            byte_ready;
  logic [6:0]      key_addr = 7'd0;
  logic [7:0][7:0] key_data;
  logic            key_ready;
  logic [6:0]      key_len;
  logic            truncated;

  key_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .key_addr   (key_addr),
    .key_data   (key_data),
    .key_ready  (key_ready),
    .key_len    (key_len),
    .truncated  (truncated)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        br;
    logic        kr;
    logic [6:0]  len;
    logic        tr;
    logic [63:0] data;
  } snap_t;

  typedef struct {
    logic [6:0] len;
    logic       tr;
    int         due;
  } rdy_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  snap_t      snap_q[$];
  rdy_t       rdy_q[$];
  logic       snap_en = 1'b0;
  logic       kr_prev = 1'b0;
  logic [7:0] exp_stream [72];
  int         exp_len = 0;
  logic       exp_trunc = 1'b0;
  logic [7:0] pw[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: times key_ready rises and compares requested snapshots.
  always @(negedge clk) begin
    rdy_t  r;
    snap_t s;
    if (key_ready === 1'b1 && kr_prev !== 1'b1) begin
      if (rdy_q.size() == 0) begin
        chk("unexpected_key_ready", 64'(1), 64'(0));
      end else begin
        r = rdy_q.pop_front();
        chk("ready_cycle", 64'(cyc), 64'(r.due));
        chk("ready_key_len", 64'(key_len), 64'(r.len));
        chk("ready_truncated", 64'(truncated), 64'(r.tr));
      end
    end
    kr_prev = key_ready;
    if (snap_en) begin
      if (snap_q.size() == 0) begin
        chk("snapshot_queue_empty", 64'(1), 64'(0));
      end else begin
        s = snap_q.pop_front();
        chk({s.name, "_byte_ready"}, 64'(byte_ready), 64'(s.br));
        chk({s.name, "_key_ready"}, 64'(key_ready), 64'(s.kr));
        chk({s.name, "_key_len"}, 64'(key_len), 64'(s.len));
        chk({s.name, "_truncated"}, 64'(truncated), 64'(s.tr));
        chk({s.name, "_key_data"}, key_data, s.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    snap_en = 1'b0;
  endtask

  task automatic snap(input string name, input logic br, input logic kr,
                      input logic [6:0] len, input logic tr, input logic [63:0] data);
    snap_q.push_back('{name, br, kr, len, tr, data});
    snap_en = 1'b1;
  endtask

  // Reference: stored bytes (plus optional NUL) repeated to 72 bytes.
  function automatic void model(input logic [7:0] p[$]);
    logic [7:0] st[$];
    for (int i = 0; i < p.size() && i < 72; i++) st.push_back(p[i]);
`ifdef KEY_NUL_TERM_EN
    if (st.size() < 72) st.push_back(8'h00);
`endif
    exp_len   = st.size();
    exp_trunc = (p.size() > 72);
    for (int j = 0; j < 72; j++) exp_stream[j] = (exp_len == 0) ? 8'h00 : st[j % exp_len];
  endfunction

  function automatic logic [63:0] window(input int addr);
    logic [63:0] w = '0;
    if (addr < 72)
      for (int i = 0; i < 8; i++) w[8*i +: 8] = exp_stream[(addr + i) % 72];
    return w;
  endfunction

  task automatic do_load(input logic [7:0] p[$], input bit expect_done, input bit collide, input bit gaps);
    load_start = 1'b1;
    if (collide) begin
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      byte_last  = 1'b0;
    end
    tick();
    load_start = 1'b0;
    byte_valid = 1'b0;
    snap("load_entry", 1'b1, 1'b0, 7'd0, 1'b0, 64'd0);
    for (int i = 0; i < p.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        byte_valid = 1'b0;
        tick();
      end
      byte_valid = 1'b1;
      byte_data  = p[i];
      byte_last  = (i == p.size() - 1);
      tick();
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    if (expect_done) begin
      model(p);
      rdy_q.push_back('{7'(exp_len), exp_trunc, cyc + 72 - exp_len});
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (key_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("wait_ready_timeout", 64'(key_ready === 1'b1), 64'(1));
  endtask

  task automatic read(input int addr);
    key_addr = 7'(addr);
    snap($sformatf("read_%0d", addr), 1'b0, 1'b1, 7'(exp_len), exp_trunc, window(addr));
    tick();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int len;
    tick();
    snap("reset", 1'b0, 1'b0, 7'd0, 1'b0, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    snap("idle", 1'b0, 1'b0, 7'd0, 1'b0, 64'd0);
    tick();

    pw = '{8'h61, 8'h62, 8'h63};
    do_load(pw, 1'b1, 1'b0, 1'b0);
    wait_ready();
    read(0); read(68); read(70); read(100);
    repeat (3) read($urandom_range(0, 71));

    pw.delete();
    for (int i = 0; i < 80; i++) pw.push_back(8'(i));
    do_load(pw, 1'b1, 1'b0, 1'b1);
    wait_ready();
    read(64); read(0); read(71);

    pw = '{8'h61, 8'h62};
    do_load(pw, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    pw = '{8'h78, 8'h79, 8'h7A};
    do_load(pw, 1'b1, 1'b0, 1'b0);
    wait_ready();
    read(0); read(3);

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    pw = '{8'h41};
    do_load(pw, 1'b1, 1'b1, 1'b0);
    wait_ready();
    read(0); read(71);

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h33;
    tick(); tick();
    reset = 1'b1;
    #1;
    snap("reset_mid_load", 1'b0, 1'b0, 7'd0, 1'b0, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    snap("after_reset", 1'b0, 1'b0, 7'd0, 1'b0, 64'd0);
    tick();
    snap("after_reset_2", 1'b0, 1'b0, 7'd0, 1'b0, 64'd0);
    tick();
    byte_valid = 1'b0;

    pw = '{8'h01, 8'h02, 8'h03};
    do_load(pw, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    snap("reset_mid_expand", 1'b0, 1'b0, 7'd0, 1'b0, 64'd0);
    tick();
    reset = 1'b0;
    repeat (80) tick();
    snap("idle_after_expand_reset", 1'b0, 1'b0, 7'd0, 1'b0, 64'd0);
    tick();

    for (int t = 0; t < 8; t++) begin
      case (t)
        0: len = 71;
        1: len = 72;
        2: len = 73;
        3: len = 1;
        default: len = $urandom_range(1, 90);
      endcase
      pw.delete();
      for (int i = 0; i < len; i++) pw.push_back(8'($urandom_range(0, 255)));
      do_load(pw, 1'b1, 1'b0, 1'b1);
      wait_ready();
      read(0); read(71);
      repeat (4) read($urandom_range(0, 71));
    end

    chk("ready_queue_drained", 64'(rdy_q.size()), 64'(0));
    chk("snapshot_queue_drained", 64'(snap_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
